// File: rtl/ret_store_buf_if.sv
// Signal bundle for the post-retirement store buffer: dispatch allocation, AGU fill,
// ROB retire lanes, data-memory drain handshake and occupancy/error status.
interface ret_store_buf_if #(
  parameter int SB_CLOG        = 3,
  parameter int ROB_MAX_RETIRE = 4,
  parameter int ROB_SIZE_CLOG  = 6,
  parameter int XLEN           = 32
);
  logic                                    alloc_v;
  logic [ROB_SIZE_CLOG-1:0]                alloc_robid;
  logic                                    alloc_rdy;
  logic                                    fill_v;
  logic [ROB_SIZE_CLOG-1:0]                fill_robid;
  logic [XLEN-1:0]                         fill_addr;
  logic [XLEN-1:0]                         fill_data;
  logic [XLEN/8-1:0]                       fill_be;
  logic [ROB_MAX_RETIRE-1:0]               ret_v;
  logic [ROB_MAX_RETIRE-1:0]               ret_memwrite;
  logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0] ret_robid;
  logic                                    mem_req_v;
  logic [XLEN-1:0]                         mem_req_addr;
  logic [XLEN-1:0]                         mem_req_data;
  logic [XLEN/8-1:0]                       mem_req_be;
  logic                                    mem_req_rdy;
  logic [SB_CLOG:0]                        sb_count;
  logic                                    sb_empty;
  logic                                    sb_err;

  modport master (
    output alloc_v, alloc_robid,
    input  alloc_rdy,
    output fill_v, fill_robid, fill_addr, fill_data, fill_be,
    output ret_v, ret_memwrite, ret_robid,
    input  mem_req_v, mem_req_addr, mem_req_data, mem_req_be,
    output mem_req_rdy,
    input  sb_count, sb_empty, sb_err
  );

  modport slave (
    input  alloc_v, alloc_robid,
    output alloc_rdy,
    input  fill_v, fill_robid, fill_addr, fill_data, fill_be,
    input  ret_v, ret_memwrite, ret_robid,
    output mem_req_v, mem_req_addr, mem_req_data, mem_req_be,
    input  mem_req_rdy,
    output sb_count, sb_empty, sb_err
  );
endinterface

// File: rtl/ret_store_buf.sv
// Post-retirement store buffer: entries allocated in program order, filled by the AGU,
// committed by ROB retire lanes, and drained in order to the data-memory port.
module ret_store_buf #(
  parameter int SB_DEPTH       = 8,
  parameter int SB_CLOG        = 3,
  parameter int ROB_MAX_RETIRE = 4,
  parameter int ROB_SIZE_CLOG  = 6,
  parameter int XLEN           = 32
) (
  input logic            clk,
  input logic            rst,
  ret_store_buf_if.slave sb
);
  localparam int BE_W = XLEN / 8;

  typedef logic [SB_CLOG-1:0] ptr_t;
  typedef logic [SB_CLOG:0]   cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(SB_DEPTH);

  logic [SB_DEPTH-1:0]      ent_v;
  logic [SB_DEPTH-1:0]      ent_filled;
  logic [SB_DEPTH-1:0]      ent_committed;
  logic [ROB_SIZE_CLOG-1:0] ent_robid [SB_DEPTH];
  logic [XLEN-1:0]          ent_addr  [SB_DEPTH];
  logic [XLEN-1:0]          ent_data  [SB_DEPTH];
  logic [BE_W-1:0]          ent_be    [SB_DEPTH];

  ptr_t alloc_ptr;
  ptr_t cmt_ptr;
  ptr_t head_ptr;
  cnt_t count;
  logic err;

  logic                alloc_rdy;
  logic                alloc_acc;
  logic                head_ready;
  logic                pop;
  logic                fill_hit;
  ptr_t                fill_idx;
  logic                fill_ok;
  logic                fill_bad;
  logic [SB_DEPTH-1:0] cmt_mask;
  ptr_t                cmt_next;
  logic                cmt_bad;

  // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign alloc_rdy  = (count < CNT_FULL);
  assign alloc_acc  = sb.alloc_v & alloc_rdy;
  assign head_ready = ent_v[head_ptr] & ent_committed[head_ptr] & ent_filled[head_ptr];
  assign pop        = head_ready & sb.mem_req_rdy;

  assign sb.alloc_rdy    = alloc_rdy;
  assign sb.mem_req_v    = head_ready;
  assign sb.mem_req_addr = ent_addr[head_ptr];
  assign sb.mem_req_data = ent_data[head_ptr];
  assign sb.mem_req_be   = ent_be[head_ptr];
  assign sb.sb_count     = count;
  assign sb.sb_empty     = (count == '0);
  assign sb.sb_err       = err;

  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (!fill_hit && ent_v[i] && (ent_robid[i] == sb.fill_robid)) begin
        fill_hit = 1'b1;
        fill_idx = ptr_t'(i);
      end
    end
  end

  // A fill landing on the entry being popped this cycle is a protocol violation, not a write.
  assign fill_ok  = sb.fill_v & fill_hit & ~(pop & (fill_idx == head_ptr));
  assign fill_bad = sb.fill_v & ~fill_ok;

  always_comb begin
    cmt_mask = '0;
    cmt_next = cmt_ptr;
    cmt_bad  = 1'b0;
    for (int l = 0; l < ROB_MAX_RETIRE; l++) begin
      if (sb.ret_v[l] && sb.ret_memwrite[l] && !cmt_bad) begin
        if (ent_v[cmt_next] && !ent_committed[cmt_next] && !cmt_mask[cmt_next] &&
            (ent_robid[cmt_next] == sb.ret_robid[l*ROB_SIZE_CLOG +: ROB_SIZE_CLOG])) begin
          cmt_mask[cmt_next] = 1'b1;
          cmt_next           = cmt_next + PTR_ONE;
        end else begin
          cmt_bad = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_v         <= '0;
      ent_filled    <= '0;
      ent_committed <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        ent_robid[i] <= '0;
        ent_addr[i]  <= '0;
        ent_data[i]  <= '0;
        ent_be[i]    <= '0;
      end
    end else begin
      if (pop) begin
        ent_v[head_ptr] <= 1'b0;
      end
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (cmt_mask[i]) begin
          ent_committed[i] <= 1'b1;
        end
      end
      if (fill_ok) begin
        ent_filled[fill_idx] <= 1'b1;
        ent_addr[fill_idx]   <= sb.fill_addr;
        ent_data[fill_idx]   <= sb.fill_data;
        ent_be[fill_idx]     <= sb.fill_be;
      end
      if (alloc_acc) begin
        ent_v[alloc_ptr]         <= 1'b1;
        ent_filled[alloc_ptr]    <= 1'b0;
        ent_committed[alloc_ptr] <= 1'b0;
        ent_robid[alloc_ptr]     <= sb.alloc_robid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr <= '0;
      cmt_ptr   <= '0;
      head_ptr  <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (alloc_acc) begin
        alloc_ptr <= alloc_ptr + PTR_ONE;
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
      cmt_ptr <= cmt_next;
      if (alloc_acc && !pop) begin
        count <= count + CNT_ONE;
      end else if (!alloc_acc && pop) begin
        count <= count - CNT_ONE;
      end
      if ((sb.alloc_v && !alloc_rdy) || fill_bad || cmt_bad) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ret_store_buf.sv
// Directed scenarios plus a randomized phase checked against a program-order queue model
// of the store buffer.
module tb_ret_store_buf;
  localparam int SB_DEPTH       = 8;
  localparam int SB_CLOG        = 3;
  localparam int ROB_MAX_RETIRE = 4;
  localparam int ROB_SIZE_CLOG  = 6;
  localparam int XLEN           = 32;

  typedef struct {
    logic [5:0]  robid;
    bit          filled;
    bit          committed;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } model_ent_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  model_ent_t mq[$];

  ret_store_buf_if #(
    .SB_CLOG(SB_CLOG), .ROB_MAX_RETIRE(ROB_MAX_RETIRE),
    .ROB_SIZE_CLOG(ROB_SIZE_CLOG), .XLEN(XLEN)
  ) sb_if ();

  ret_store_buf #(
    .SB_DEPTH(SB_DEPTH), .SB_CLOG(SB_CLOG), .ROB_MAX_RETIRE(ROB_MAX_RETIRE),
    .ROB_SIZE_CLOG(ROB_SIZE_CLOG), .XLEN(XLEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb(sb_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the currently driven inputs; single-cycle requests are dropped afterwards.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    sb_if.alloc_v      = 1'b0;
    sb_if.fill_v       = 1'b0;
    sb_if.ret_v        = '0;
    sb_if.ret_memwrite = '0;
  endtask

  function automatic logic [31:0] addrOf(input int r);
    return 32'h1000 + 32'(r * 4);
  endfunction

  function automatic logic [31:0] dataOf(input int r);
    return 32'hC0DE0000 | 32'(r);
  endfunction

  function automatic logic [3:0] beOf(input int r);
    return 4'(r) | 4'h1;
  endfunction

  task automatic setAlloc(input int r);
    sb_if.alloc_v     = 1'b1;
    sb_if.alloc_robid = 6'(r);
  endtask

  task automatic setFillVal(input int r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    sb_if.fill_v     = 1'b1;
    sb_if.fill_robid = 6'(r);
    sb_if.fill_addr  = a;
    sb_if.fill_data  = d;
    sb_if.fill_be    = b;
  endtask

  task automatic setFill(input int r);
    setFillVal(r, addrOf(r), dataOf(r), beOf(r));
  endtask

  task automatic setRet(input int lane, input int r);
    sb_if.ret_v[lane]        = 1'b1;
    sb_if.ret_memwrite[lane] = 1'b1;
    sb_if.ret_robid[lane*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] = 6'(r);
  endtask

  task automatic checkStatus(input string tag, input int cnt, input bit req_v, input bit err);
    checkOutput({tag, ".count"}, 64'(sb_if.sb_count), 64'(cnt));
    checkOutput({tag, ".empty"}, 64'(sb_if.sb_empty), 64'(cnt == 0));
    checkOutput({tag, ".alloc_rdy"}, 64'(sb_if.alloc_rdy), 64'(cnt < SB_DEPTH));
    checkOutput({tag, ".req_v"}, 64'(sb_if.mem_req_v), 64'(req_v));
    checkOutput({tag, ".err"}, 64'(sb_if.sb_err), 64'(err));
  endtask

  task automatic checkHeadVals(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    checkOutput({tag, ".req_v"}, 64'(sb_if.mem_req_v), 64'(1));
    checkOutput({tag, ".addr"}, 64'(sb_if.mem_req_addr), 64'(a));
    checkOutput({tag, ".data"}, 64'(sb_if.mem_req_data), 64'(d));
    checkOutput({tag, ".be"}, 64'(sb_if.mem_req_be), 64'(b));
  endtask

  task automatic checkHead(input string tag, input int r);
    checkHeadVals(tag, addrOf(r), dataOf(r), beOf(r));
  endtask

  task automatic doReset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
  endtask

  initial begin
    int          ncmt, avail, k, rem, ci, fidx, nq;
    bit          do_alloc, do_fill, rdy, pop, exp_v;
    logic [5:0]  arob;
    logic [5:0]  next_robid;
    logic [31:0] fa, fd;
    logic [3:0]  fb;
    int          unf[$];

    sb_if.alloc_v      = 1'b0;
    sb_if.alloc_robid  = '0;
    sb_if.fill_v       = 1'b0;
    sb_if.fill_robid   = '0;
    sb_if.fill_addr    = '0;
    sb_if.fill_data    = '0;
    sb_if.fill_be      = '0;
    sb_if.ret_v        = '0;
    sb_if.ret_memwrite = '0;
    sb_if.ret_robid    = '0;
    sb_if.mem_req_rdy  = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkStatus("reset", 0, 1'b0, 1'b0);
    checkOutput("reset.addr", 64'(sb_if.mem_req_addr), 64'(0));
    checkOutput("reset.data", 64'(sb_if.mem_req_data), 64'(0));
    checkOutput("reset.be", 64'(sb_if.mem_req_be), 64'(0));
    rst = 1'b1;

    $display("[TB] basic flow");
    setAlloc(5); applyStimulus();
    checkStatus("basic.alloc", 1, 1'b0, 1'b0);
    setFillVal(5, 32'h100, 32'hDEADBEEF, 4'hF); applyStimulus();
    checkStatus("basic.fill", 1, 1'b0, 1'b0);
    setRet(0, 5); applyStimulus();
    checkStatus("basic.commit", 1, 1'b1, 1'b0);
    checkHeadVals("basic.req", 32'h100, 32'hDEADBEEF, 4'hF);
    sb_if.mem_req_rdy = 1'b1; applyStimulus(); sb_if.mem_req_rdy = 1'b0;
    checkStatus("basic.drain", 0, 1'b0, 1'b0);

    $display("[TB] commit before fill");
    setAlloc(7); applyStimulus();
    setRet(0, 7); applyStimulus();
    checkStatus("cbf.commit", 1, 1'b0, 1'b0);
    repeat (3) begin
      applyStimulus();
      checkStatus("cbf.wait", 1, 1'b0, 1'b0);
    end
    setFillVal(7, 32'h200, 32'h12345678, 4'h3); applyStimulus();
    checkStatus("cbf.fill", 1, 1'b1, 1'b0);
    checkHeadVals("cbf.req", 32'h200, 32'h12345678, 4'h3);
    sb_if.mem_req_rdy = 1'b1; applyStimulus(); sb_if.mem_req_rdy = 1'b0;
    checkStatus("cbf.drain", 0, 1'b0, 1'b0);

    $display("[TB] backpressure and ordering");
    for (int r = 1; r <= 3; r++) begin
      setAlloc(r); applyStimulus();
    end
    setFill(3); applyStimulus();
    setFill(1); applyStimulus();
    setFill(2); applyStimulus();
    checkStatus("bp.filled", 3, 1'b0, 1'b0);
    setRet(0, 1); setRet(1, 2); setRet(2, 3); applyStimulus();
    repeat (4) begin
      checkStatus("bp.hold", 3, 1'b1, 1'b0);
      checkHead("bp.hold", 1);
      applyStimulus();
    end
    sb_if.mem_req_rdy = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      checkHead("bp.order", r);
      applyStimulus();
    end
    sb_if.mem_req_rdy = 1'b0;
    checkStatus("bp.done", 0, 1'b0, 1'b0);

    $display("[TB] full and wrap");
    for (int i = 0; i < 8; i++) begin
      setAlloc(20 + i);
      if (i > 0) setFill(19 + i);
      applyStimulus();
    end
    setFill(27); applyStimulus();
    checkStatus("full", 8, 1'b0, 1'b0);
    setAlloc(40); applyStimulus();
    checkStatus("full.overflow", 8, 1'b0, 1'b1);
    for (int l = 0; l < 4; l++) setRet(l, 20 + l);
    applyStimulus();
    checkStatus("full.cmt", 8, 1'b1, 1'b1);
    checkHead("full.head", 20);
    for (int l = 0; l < 4; l++) setRet(l, 24 + l);
    applyStimulus();
    sb_if.mem_req_rdy = 1'b1;
    applyStimulus();
    applyStimulus();
    sb_if.mem_req_rdy = 1'b0;
    checkStatus("wrap.drain2", 6, 1'b1, 1'b1);
    checkHead("wrap.head", 22);
    setAlloc(28); applyStimulus();
    setAlloc(29); setFill(28); setRet(0, 28); applyStimulus();
    setFill(29); setRet(0, 29); applyStimulus();
    checkStatus("wrap.refill", 8, 1'b1, 1'b1);
    sb_if.mem_req_rdy = 1'b1;
    for (int r = 22; r <= 29; r++) begin
      checkHead("wrap.order", r);
      applyStimulus();
    end
    sb_if.mem_req_rdy = 1'b0;
    checkStatus("wrap.empty", 0, 1'b0, 1'b1);

    $display("[TB] reset during drain");
    setAlloc(50); applyStimulus();
    setFill(50); setRet(0, 50); applyStimulus();
    checkStatus("rstmid.pre", 1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkStatus("rstmid.async", 0, 1'b0, 1'b0);
    checkOutput("rstmid.addr", 64'(sb_if.mem_req_addr), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus();
    checkStatus("rstmid.after", 0, 1'b0, 1'b0);

    $display("[TB] robid mismatch");
    setAlloc(10); applyStimulus();
    setRet(0, 11); applyStimulus();
    checkStatus("mis.ret", 1, 1'b0, 1'b1);
    setFill(10); applyStimulus();
    checkStatus("mis.fill", 1, 1'b0, 1'b1);
    setRet(0, 10); applyStimulus();
    checkStatus("mis.recommit", 1, 1'b1, 1'b1);
    checkHead("mis.head", 10);
    sb_if.mem_req_rdy = 1'b1; applyStimulus(); sb_if.mem_req_rdy = 1'b0;
    checkStatus("mis.drain", 0, 1'b0, 1'b1);

    $display("[TB] fill in allocation cycle");
    doReset();
    setAlloc(12); setFill(12); applyStimulus();
    checkStatus("nomatch", 1, 1'b0, 1'b1);

    $display("[TB] randomized traffic");
    doReset();
    next_robid = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ncmt = 0;
      foreach (mq[i]) if (mq[i].committed) ncmt++;

      do_alloc = (mq.size() < SB_DEPTH) && ($urandom_range(0, 3) != 0);
      arob = next_robid;
      if (do_alloc) begin
        setAlloc(int'(arob));
        next_robid = next_robid + 6'd1;
      end

      unf.delete();
      foreach (mq[i]) if (!mq[i].filled) unf.push_back(i);
      do_fill = (unf.size() > 0) && ($urandom_range(0, 1) == 1);
      fidx = 0;
      fa = $urandom; fd = $urandom; fb = 4'($urandom);
      if (do_fill) begin
        fidx = unf[$urandom_range(0, unf.size() - 1)];
        setFillVal(int'(mq[fidx].robid), fa, fd, fb);
      end

      avail = mq.size() - ncmt;
      k = (avail > ROB_MAX_RETIRE) ? ROB_MAX_RETIRE : avail;
      k = $urandom_range(0, k);
      rem = k;
      ci = ncmt;
      for (int l = 0; l < ROB_MAX_RETIRE; l++) begin
        sb_if.ret_robid[l*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] = 6'($urandom);
        if (rem > 0 && ($urandom_range(0, 1) == 1 || (ROB_MAX_RETIRE - l) == rem)) begin
          setRet(l, int'(mq[ci].robid));
          ci++;
          rem--;
        end else begin
          nq = $urandom_range(0, 2);
          sb_if.ret_v[l]        = (nq == 1);
          sb_if.ret_memwrite[l] = (nq == 2);
        end
      end

      rdy = ($urandom_range(0, 3) != 0);
      sb_if.mem_req_rdy = rdy;
      pop = (mq.size() > 0) && mq[0].committed && mq[0].filled && rdy;
      applyStimulus();

      if (do_fill) begin
        mq[fidx].filled = 1'b1;
        mq[fidx].addr   = fa;
        mq[fidx].data   = fd;
        mq[fidx].be     = fb;
      end
      for (int j = 0; j < k; j++) mq[ncmt + j].committed = 1'b1;
      if (pop) void'(mq.pop_front());
      if (do_alloc) mq.push_back('{robid: arob, filled: 1'b0, committed: 1'b0, addr: '0, data: '0, be: '0});

      exp_v = (mq.size() > 0) && mq[0].committed && mq[0].filled;
      checkStatus("rand", mq.size(), exp_v, 1'b0);
      if (exp_v) checkHeadVals("rand.head", mq[0].addr, mq[0].data, mq[0].be);
    end
    sb_if.mem_req_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
